// File: rtl/operand_stage.sv
// Operand formation stage: builds ALU operands A/B and buffers them in a 2-entry FIFO.
// Optional stall counter output is enabled by defining OPERAND_STAGE_STALL_CNT_EN.
module operand_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
`ifdef OPERAND_STAGE_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        ALUop
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
  } entry_t;

  function automatic logic [DATA_W-1:0] shift_b(input logic signed [DATA_W-1:0] v,
                                                input logic [1:0] sh);
    logic signed [DATA_W-1:0] r;
    case (sh)
      2'b01:   r = v <<< 1;
      2'b10:   r = $signed($unsigned(v) >> 1);
      2'b11:   r = v >>> 1;
      default: r = v;
    endcase
    return $unsigned(r);
  endfunction

  state_t state_q, state_d;
  logic   wr_ptr_q, wr_ptr_d;
  logic   rd_ptr_q, rd_ptr_d;
  entry_t mem_q [2];
  entry_t mem_d [2];
  entry_t head_q, head_d;
  entry_t new_entry;
  logic   push, pop, push_ok;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & ~flush;

  assign Ain   = head_q.a;
  assign Bin   = head_q.b;
  assign ALUop = head_q.op;

  always_comb begin
    new_entry.a  = asel ? '0 : rd_a;
    new_entry.b  = bsel ? imm : shift_b($signed(rd_b), shift);
    new_entry.op = op;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = new_entry;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (push && !pop) state_d = FULL;
                 else if (pop && !push) state_d = EMPTY;
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
      // Next head may be the entry being written this very cycle.
      if (state_d != EMPTY)
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? new_entry : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef OPERAND_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: driver pushes expected entries, negedge monitor checks.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] rd_a = '0, rd_b = '0, imm = '0;
  logic [1:0]  shift = '0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;
`ifdef OPERAND_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          model_stall = 0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] sb[$];
  logic [33:0] last_head = '0;
  int          pushed_now = 0;
  int          exp_occ;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rd_a(rd_a), .rd_b(rd_b), .imm(imm), .shift(shift), .asel(asel), .bsel(bsel),
    .op(op), .out_valid(out_valid), .out_ready(out_ready), .Ain(Ain), .Bin(Bin),
`ifdef OPERAND_STAGE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] model(input logic [15:0] a, b, im, input logic [1:0] sh,
                                        input logic as_, bs_, input logic [1:0] o);
    int unsigned ea, eb;
    ea = as_ ? 0 : a;
    if (bs_) eb = im;
    else case (sh)
      2'd1:    eb = (b * 2) % 65536;
      2'd2:    eb = b / 2;
      2'd3:    eb = b / 2 + (b >= 16'h8000 ? 32'h8000 : 0);
      default: eb = b;
    endcase
    return {ea[15:0], eb[15:0], o};
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [15:0] a, b, im, input logic [1:0] sh,
                       input logic as_, bs_, input logic [1:0] o);
    @(posedge clk); #1;
    in_valid = iv; out_ready = ordy; flush = fl;
    rd_a = a; rd_b = b; imm = im; shift = sh; asel = as_; bsel = bs_; op = o;
    pushed_now = (iv && (sb.size() < 2) && !fl) ? 1 : 0;
    if (pushed_now == 1) sb.push_back(model(a, b, im, sh, as_, bs_, o));
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, ordy, 1'b0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic push1(input logic ordy, input logic [15:0] a, b, im, input logic [1:0] sh,
                       input logic bs_, input logic [1:0] o);
    drive(1'b1, ordy, 1'b0, a, b, im, sh, 1'b0, bs_, o);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_Ain"}, Ain, 0);
    chk({tag, "_Bin"}, Bin, 0);
    chk({tag, "_ALUop"}, ALUop, 0);
  endtask

  task automatic model_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    sb.delete();
    pushed_now = 0;
    last_head = '0;
`ifdef OPERAND_STAGE_STALL_CNT_EN
    model_stall = 0;
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_occ = sb.size() - pushed_now;
      chk("out_valid", out_valid, exp_occ != 0);
      chk("in_ready", in_ready, exp_occ < 2);
      if (out_valid && exp_occ > 0) chk("head", {Ain, Bin, ALUop}, sb[0]);
      else if (!out_valid) chk("hold", {Ain, Bin, ALUop}, last_head);
      if (out_valid) last_head = {Ain, Bin, ALUop};
`ifdef OPERAND_STAGE_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, model_stall);
      if (flush) model_stall = 0;
      else if (exp_occ != 0 && !out_ready && model_stall < 65535) model_stall++;
`endif
      if (flush) sb.delete();
      else if (out_valid && out_ready && exp_occ > 0) void'(sb.pop_front());
    end
  end

  initial begin
    model_reset();
    #2;
    check_reset_values("por");
    #10 rst_n = 1'b1;

    // Basic push with left shift
    push1(1'b0, 16'h0003, 16'h0005, 16'h0, 2'd1, 1'b0, 2'd0);
    idle(1'b0);
    chk("basic_Ain", Ain, 16'h0003);
    chk("basic_Bin", Bin, 16'h000A);
    chk("basic_ALUop", ALUop, 2'd0);
    idle(1'b1);
    idle(1'b0);

    // Shifter variants and immediate bypass, streaming with out_ready high
    push1(1'b1, 16'h1111, 16'h8002, 16'h0, 2'd3, 1'b0, 2'd1);
    push1(1'b1, 16'h2222, 16'h8002, 16'h0, 2'd2, 1'b0, 2'd2);
    chk("asr_Bin", Bin, 16'hC001);
    push1(1'b1, 16'h3333, 16'h8002, 16'hFFFF, 2'd3, 1'b1, 2'd3);
    chk("lsr_Bin", Bin, 16'h4001);
    idle(1'b1);
    chk("imm_Bin", Bin, 16'hFFFF);
    idle(1'b0);

    // Fill to FULL, third offer ignored, then drain in order
    push1(1'b0, 16'hAAAA, 16'h0001, 16'h0, 2'd0, 1'b0, 2'd1);
    push1(1'b0, 16'hBBBB, 16'h0002, 16'h0, 2'd0, 1'b0, 2'd2);
    push1(1'b0, 16'hCCCC, 16'h0003, 16'h0, 2'd0, 1'b0, 2'd3);
    chk("full_in_ready", in_ready, 0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Push and pop together in ONE across pointer wrap
    push1(1'b0, 16'h0100, 16'h0200, 16'h0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      push1(1'b1, 16'h0101 + 16'(i), 16'h0300 + 16'(i), 16'h0, 2'(i), 1'b0, 2'(i));
      if (i > 0) chk("one_steady", {out_valid, in_ready}, 2'b11);
    end
    idle(1'b1);
    idle(1'b0);

`ifdef OPERAND_STAGE_STALL_CNT_EN
    // Three stalled cycles then count check
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 2'd0);
    push1(1'b0, 16'h0ABC, 16'h0001, 16'h0, 2'd0, 1'b0, 2'd0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("stall_cnt3", stall_cnt, 16'd3);
    idle(1'b0);
`endif

    // Flush in FULL with a same-cycle offer
    push1(1'b0, 16'hD000, 16'h0010, 16'h0, 2'd0, 1'b0, 2'd0);
    push1(1'b0, 16'hD001, 16'h0011, 16'h0, 2'd0, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 16'h0, 2'd0, 1'b0, 1'b0, 2'd2);
    idle(1'b1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    idle(1'b1);

    // Asynchronous reset while FULL
    push1(1'b0, 16'hE000, 16'h0020, 16'h0, 2'd0, 1'b0, 2'd1);
    push1(1'b0, 16'hE001, 16'h0021, 16'h0, 2'd0, 1'b0, 2'd2);
    idle(1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_reset_values("midrst");
    @(posedge clk); #2 rst_n = 1'b1;
    push1(1'b1, 16'hF00D, 16'h0004, 16'h0, 2'd2, 1'b0, 2'd3);
    idle(1'b1);
    chk("post_rst_Bin", Bin, 16'h0002);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0),
            16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 2'($urandom));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
